muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the MIPS datapath. Executes MULT, MULTU, DIV and DIVU
//  over many cycles, beside the single-cycle ALU. Results go into HI/LO, which are read by
//  MFHI/MFLO. The control unit issues an operation with a start pulse and stalls the pipeline
//  while busy is high.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; the iteration count equals WIDTH
// PORTS
//  clk      in   1      rising-edge clock
//  reset_n  in   1      asynchronous, active-low reset
//  start    in   1      request; sampled only in IDLE
//  op       in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
//  A, B     in   WIDTH  operands (rs, rt); sampled with start
//  mthi     in   1      write wdata into HI; honoured only in IDLE
//  mtlo     in   1      write wdata into LO; honoured only in IDLE
//  wdata    in   WIDTH  data for mthi/mtlo
//  busy     out  1      operation in progress
//  done     out  1      one-cycle pulse; HI/LO hold the new result
//  dbz      out  1      divide by zero; registered with done, holds until the next start
//  hi, lo   out  WIDTH  HI/LO registers
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; busy=done=dbz=0; hi=lo=0; all internal regs cleared.
//  States and transitions:
//   - IDLE: start=1 -> RUN. Latches op. Latches |A| and |B| for signed ops, raw A and B for
//     unsigned ops. Latches sign_q=A[W-1]^B[W-1] and sign_r=A[W-1] (signed ops only).
//     Clears the iteration counter and the 2W accumulator.
//   - RUN: exactly WIDTH cycles, one bit per cycle.
//     Multiply: shift-add on the 2W accumulator.
//     Divide: restoring; shift remainder left, trial-subtract divisor, set quotient bit if no borrow.
//     The counter reaching WIDTH-1 -> FIX.
//   - FIX: one cycle.
//     Signed ops: negate the 64-bit product if sign_q=1; negate the quotient if sign_q=1;
//     negate the remainder if sign_r=1.
//     Write hi/lo: product[2W-1:W]/product[W-1:0]; remainder/quotient for divides.
//     Then -> DONE.
//   - DONE: done=1 for one cycle, busy=0 -> IDLE. A start in DONE is ignored.
//  Latency: start sampled at edge k -> busy=1 after edge k. hi/lo update at edge k+WIDTH+1.
//   done=1 and busy=0 from edge k+WIDTH+1 to k+WIDTH+2. Total is 34 cycles for WIDTH=32.
//  busy is 1 in RUN and FIX, and 0 in IDLE and DONE.
//  hi/lo are constant while busy; they change only in FIX, or in IDLE via mthi/mtlo.
//  Divide by zero (B==0, DIV or DIVU): same latency. lo=all ones, hi=A (original dividend), dbz=1.
//  DIV overflow (A=0x80000000, B=0xFFFFFFFF): lo=0x80000000, hi=0, dbz=0.
//  Simultaneous events in IDLE:
//   - start together with mthi/mtlo: start wins; the mt write is dropped.
//   - mthi and mtlo together: both registers are written.
//  start, mthi and mtlo while busy or in DONE: ignored; no queuing.
//  Reset mid-operation: aborts immediately. hi/lo=0, no done pulse. The next start after reset
//   proceeds normally.
//  All arithmetic is modulo 2^W per half. Operand changes after the start edge have no effect.
// TESTING
//  MULT A=0xFFFFFFFD (-3), B=7 -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB, dbz=0.
//  MULTU A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//  DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIVU A=100, B=0 -> dbz=1, lo=0xFFFFFFFF, hi=0x00000064.
//  DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
//  DIV A=20, B=3, then reset_n=0 at cycle 10 -> busy=0, hi=lo=0, no done.
//   Then MULTU 5*6 -> lo=30.
//  Protocol checks:
//   - start and mthi during busy are ignored; the result is unchanged.
//   - mthi=1, mtlo=1, wdata=0xA5A5A5A5 in IDLE -> hi=lo=0xA5A5A5A5 next cycle.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit writing HI/LO, one result bit per cycle.
// Rev 1.0
`default_nettype none

module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic               divz_q, divz_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               in_signed;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [2*WIDTH-1:0] mul_addend, mul_next;
    logic [WIDTH+1:0]   div_trial;
    logic               div_borrow;
    logic [2*WIDTH-1:0] div_next;
    logic               q_signed;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    assign in_signed = ~op[0];
    assign a_abs     = (in_signed && A[WIDTH-1]) ? (-A) : A;
    assign b_abs     = (in_signed && B[WIDTH-1]) ? (-B) : B;

    // Multiply consumes the multiplier MSB-first: acc = 2*acc + bit*multiplicand.
    assign mul_addend = a_q[WIDTH-1] ? {{WIDTH{1'b0}}, b_q} : '0;
    assign mul_next   = {acc_q[2*WIDTH-2:0], 1'b0} + mul_addend;

    // Divide: acc = {remainder, quotient}; the dividend shifts out of a_q MSB-first.
    assign div_trial  = {1'b0, acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]} - {2'b00, b_q};
    assign div_borrow = div_trial[WIDTH+1];
    assign div_next   = {div_borrow ? {acc_q[2*WIDTH-2:WIDTH], a_q[WIDTH-1]} : div_trial[WIDTH-1:0],
                         acc_q[WIDTH-2:0], ~div_borrow};

    assign q_signed = ~op_q[0];
    assign prod_fix = (q_signed && negq_q) ? (-acc_q) : acc_q;
    assign quot_fix = (q_signed && negq_q) ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    assign rem_fix  = (q_signed && negr_q) ? (-acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        divz_d  = divz_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    op_d    = op;
                    a_d     = a_abs;
                    b_d     = b_abs;
                    acc_d   = '0;
                    cnt_d   = '0;
                    negq_d  = in_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                    negr_d  = in_signed & A[WIDTH-1];
                    divz_d  = op[1] & (B == '0);
                    dbz_d   = 1'b0;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = op_q[1] ? div_next : mul_next;
                a_d   = {a_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    // A zero divisor leaves rem = |A|, so sign restore already yields hi = A.
                    hi_d  = rem_fix;
                    lo_d  = divz_q ? '1 : quot_fix;
                    dbz_d = divz_q;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            divz_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            divz_q  <= divz_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN) || (state_q == S_FIX);
    assign done = (state_q == S_DONE);
    assign dbz  = dbz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire
